// File: rtl/card_dealer.sv
// 52-card dealer: deck register array shuffled in place by a Fisher-Yates
// walk driven by a 16-bit Galois LFSR, then dealt one card per request.
module card_dealer #(
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          AUTO_SHUFFLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       deal_req,
   input  logic       shuffle_req,
   output logic [5:0] card,
   output logic       card_valid,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SHUFFLE = 2'd1;
   localparam logic [1:0] READY   = 2'd2;

   // An all-zero Galois LFSR locks up, so a zero seed is forced to 1.
   localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [1:0]  RESET_STATE = (AUTO_SHUFFLE != 0) ? SHUFFLE : IDLE;
   localparam logic [15:0] LFSR_MASK   = 16'hB400;

   logic [5:0]  deck [52];
   logic [15:0] lfsr;
   logic [1:0]  state;
   logic [5:0]  idx;
   logic [5:0]  top;
   logic [5:0]  r;
   logic        swap_ok;
   logic        deal_ok;

   assign r       = lfsr[5:0];
   // A candidate r larger than idx is rejected and retried next cycle,
   // which keeps every swap target inside 0..idx.
   assign swap_ok = (state == SHUFFLE) && !shuffle_req && (r <= idx);
   assign deal_ok = (state != SHUFFLE) && !shuffle_req && deal_req && (cards_left != 6'd0);

   assign deck_empty = (cards_left == 6'd0);
   assign busy       = (state == SHUFFLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else begin
         lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
      end
   end

   // NOTE: the deck is a flop array rather than a RAM because reset must
   // restore identity order instantly; a RAM could not be cleared that way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 52; k++) begin
            deck[k] <= 6'(k);
         end
      end else if (swap_ok) begin
         deck[idx] <= deck[r];
         deck[r]   <= deck[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_STATE;
         idx        <= 6'd51;
         top        <= 6'd0;
         cards_left <= 6'd52;
         card       <= 6'd0;
         card_valid <= 1'b0;
      end else begin
         card_valid <= 1'b0;
         if (shuffle_req) begin
            state      <= SHUFFLE;
            idx        <= 6'd51;
            top        <= 6'd0;
            cards_left <= 6'd52;
         end else if (state == SHUFFLE) begin
            if (swap_ok) begin
               if (idx == 6'd1) begin
                  state <= READY;
               end else begin
                  idx <= idx - 6'd1;
               end
            end
         end else if (deal_ok) begin
            // top + cards_left is always 52, so top < 52 whenever a card is dealt.
            card       <= deck[top];
            card_valid <= 1'b1;
            top        <= top + 6'd1;
            cards_left <= cards_left - 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: three instances (identity order, auto shuffle with
// default seed, auto shuffle with a zero seed) checked against a deck model.
module tb_card_dealer;

   localparam int NI = 3;

   logic       clk;
   logic       rst_n;
   logic       deal_req;
   logic       shuffle_req;
   logic [5:0] card_w     [NI];
   logic       valid_w    [NI];
   logic [5:0] left_w     [NI];
   logic       empty_w    [NI];
   logic       busy_w     [NI];

   int tests_run;
   int tests_failed;

   int seq_b [3][52];
   int seq_c [3][52];

   card_dealer #(.LFSR_SEED(16'hACE1), .AUTO_SHUFFLE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .deal_req(deal_req), .shuffle_req(shuffle_req),
      .card(card_w[0]), .card_valid(valid_w[0]), .cards_left(left_w[0]),
      .deck_empty(empty_w[0]), .busy(busy_w[0]));

   card_dealer #(.LFSR_SEED(16'hACE1), .AUTO_SHUFFLE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .deal_req(deal_req), .shuffle_req(shuffle_req),
      .card(card_w[1]), .card_valid(valid_w[1]), .cards_left(left_w[1]),
      .deck_empty(empty_w[1]), .busy(busy_w[1]));

   card_dealer #(.LFSR_SEED(16'h0000), .AUTO_SHUFFLE(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .deal_req(deal_req), .shuffle_req(shuffle_req),
      .card(card_w[2]), .card_valid(valid_w[2]), .cards_left(left_w[2]),
      .deck_empty(empty_w[2]), .busy(busy_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: a deck, a dealt count, a shuffle walk
   int          m_deck  [NI][52];
   logic [15:0] m_lfsr  [NI];
   bit          m_shuf  [NI];
   int          m_i     [NI];
   int          m_top   [NI];
   int          m_left  [NI];
   int          m_card  [NI];
   bit          m_valid [NI];

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
   endfunction

   function automatic logic [15:0] seed_of(input int n);
      return (n == 2) ? 16'h0001 : 16'hACE1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NI; n++) begin
            for (int k = 0; k < 52; k++) m_deck[n][k] = k;
            m_lfsr[n]  = seed_of(n);
            m_shuf[n]  = (n != 0);
            m_i[n]     = 51;
            m_top[n]   = 0;
            m_left[n]  = 52;
            m_card[n]  = 0;
            m_valid[n] = 1'b0;
         end
      end else begin
         for (int n = 0; n < NI; n++) begin
            int r;
            int t;
            r          = int'(m_lfsr[n][5:0]);
            m_lfsr[n]  = lfsr_step(m_lfsr[n]);
            m_valid[n] = 1'b0;
            if (shuffle_req) begin
               m_shuf[n] = 1'b1;
               m_i[n]    = 51;
               m_top[n]  = 0;
               m_left[n] = 52;
            end else if (m_shuf[n]) begin
               if (r <= m_i[n]) begin
                  t                  = m_deck[n][m_i[n]];
                  m_deck[n][m_i[n]]  = m_deck[n][r];
                  m_deck[n][r]       = t;
                  if (m_i[n] == 1) m_shuf[n] = 1'b0;
                  else             m_i[n]    = m_i[n] - 1;
               end
            end else if (deal_req && m_left[n] > 0) begin
               m_card[n]  = m_deck[n][m_top[n]];
               m_valid[n] = 1'b1;
               m_top[n]   = m_top[n] + 1;
               m_left[n]  = m_left[n] - 1;
            end
         end
      end
   end

   function automatic logic [14:0] expv(input int n);
      return {6'(m_card[n]), m_valid[n], 6'(m_left[n]), (m_left[n] == 0), m_shuf[n]};
   endfunction

   function automatic logic [14:0] obsv(input int n);
      return {card_w[n], valid_w[n], left_w[n], empty_w[n], busy_w[n]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Gapped deals; every cycle all instances are compared to the model.
   task automatic deal_n(input int count, input int slot);
      for (int k = 0; k < count; k++) begin
         deal_req = 1'b1;
         tick();
         deal_req = 1'b0;
         for (int n = 0; n < NI; n++) begin
            tests_run++;
            if (obsv(n) !== expv(n)) begin
               tests_failed++;
               $display("FAIL deal inst%0d k=%0d: got %h expected %h", n, k, obsv(n), expv(n));
            end
         end
         if (slot >= 0) begin
            seq_b[slot][k] = int'(card_w[1]);
            seq_c[slot][k] = int'(card_w[2]);
         end
         tick();
      end
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while ((busy_w[1] || busy_w[2]) && cycles < 4000) begin
         tick();
         cycles++;
         for (int n = 0; n < NI; n++) begin
            tests_run++;
            if (obsv(n) !== expv(n)) begin
               tests_failed++;
               $display("FAIL shuffle inst%0d cyc=%0d: got %h expected %h", n, cycles, obsv(n), expv(n));
            end
         end
      end
      tests_run++;
      if (busy_w[1] || busy_w[2]) begin
         tests_failed++;
         $display("FAIL shuffle_timeout: busy b=%0b c=%0b after %0d cycles, expected 0", busy_w[1], busy_w[2], cycles);
      end
   endtask

   task automatic check_perm(input int slot);
      int cnt_b [52];
      int cnt_c [52];
      for (int v = 0; v < 52; v++) begin
         cnt_b[v] = 0;
         cnt_c[v] = 0;
      end
      for (int k = 0; k < 52; k++) begin
         if (seq_b[slot][k] < 52) cnt_b[seq_b[slot][k]]++;
         if (seq_c[slot][k] < 52) cnt_c[seq_c[slot][k]]++;
      end
      for (int v = 0; v < 52; v++) begin
         tests_run++;
         if (cnt_b[v] != 1 || cnt_c[v] != 1) begin
            tests_failed++;
            $display("FAIL permutation slot%0d value %0d: seen b=%0d c=%0d, expected 1", slot, v, cnt_b[v], cnt_c[v]);
         end
      end
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      repeat (8) tick();
      #2 rst_n = 1'b0;
      #1;
      for (int n = 0; n < NI; n++) begin
         tests_run++;
         if (card_w[n] !== 6'd0 || valid_w[n] !== 1'b0 || left_w[n] !== 6'd52 ||
             empty_w[n] !== 1'b0 || busy_w[n] !== (n != 0)) begin
            tests_failed++;
            $display("FAIL async_reset inst%0d: got card=%0d v=%0b left=%0d e=%0b busy=%0b, expected 0 0 52 0 %0b",
                     n, card_w[n], valid_w[n], left_w[n], empty_w[n], busy_w[n], (n != 0));
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_identity_deal();
      for (int k = 0; k < 52; k++) begin
         deal_req = 1'b1;
         tick();
         deal_req = 1'b0;
         tests_run++;
         if (card_w[0] !== 6'(k) || valid_w[0] !== 1'b1 || left_w[0] !== 6'(51 - k)) begin
            tests_failed++;
            $display("FAIL identity_deal k=%0d: got card=%0d v=%0b left=%0d, expected %0d 1 %0d",
                     k, card_w[0], valid_w[0], left_w[0], k, 51 - k);
         end
         for (int n = 1; n < NI; n++) begin
            tests_run++;
            if (obsv(n) !== expv(n)) begin
               tests_failed++;
               $display("FAIL busy_deal inst%0d k=%0d: got %h expected %h", n, k, obsv(n), expv(n));
            end
         end
         tick();
         tests_run++;
         if (valid_w[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_pulse k=%0d: got %0b expected 0", k, valid_w[0]);
         end
      end
      tests_run++;
      if (empty_w[0] !== 1'b1 || left_w[0] !== 6'd0) begin
         tests_failed++;
         $display("FAIL deck_empty: got e=%0b left=%0d expected 1 0", empty_w[0], left_w[0]);
      end
      deal_req = 1'b1;
      tick();
      deal_req = 1'b0;
      tests_run++;
      if (valid_w[0] !== 1'b0 || left_w[0] !== 6'd0 || card_w[0] !== 6'd51) begin
         tests_failed++;
         $display("FAIL deal_when_empty: got v=%0b left=%0d card=%0d expected 0 0 51", valid_w[0], left_w[0], card_w[0]);
      end
   endtask

   task automatic test_auto_shuffle(input int slot);
      int cycles;
      wait_idle(cycles);
      tests_run++;
      if (cycles < 51) begin
         tests_failed++;
         $display("FAIL shuffle_length slot%0d: got %0d cycles, expected >= 51", slot, cycles);
      end
      repeat (int'($urandom_range(0, 3))) tick();
      deal_n(52, slot);
      check_perm(slot);
   endtask

   task automatic test_seed();
      bit same_rerun;
      bit differs;
      same_rerun = 1'b1;
      differs    = 1'b0;
      for (int k = 0; k < 52; k++) begin
         if (seq_b[0][k] != seq_b[1][k] || seq_c[0][k] != seq_c[1][k]) same_rerun = 1'b0;
         if (seq_b[0][k] != seq_c[0][k]) differs = 1'b1;
      end
      tests_run++;
      if (!same_rerun) begin
         tests_failed++;
         $display("FAIL repeatability: got differing sequences on rerun, expected identical");
      end
      tests_run++;
      if (!differs) begin
         tests_failed++;
         $display("FAIL seed_change: got identical sequences for seeds ACE1 and 0, expected different");
      end
   endtask

   task automatic test_collision();
      int cycles;
      release_reset();
      wait_idle(cycles);
      deal_n(22, -1);
      deal_req    = 1'b1;
      shuffle_req = 1'b1;
      tick();
      deal_req    = 1'b0;
      shuffle_req = 1'b0;
      tests_run++;
      if (valid_w[1] !== 1'b0 || busy_w[1] !== 1'b1 || left_w[1] !== 6'd52) begin
         tests_failed++;
         $display("FAIL deal_shuffle_collision: got v=%0b busy=%0b left=%0d, expected 0 1 52",
                  valid_w[1], busy_w[1], left_w[1]);
      end
   endtask

   task automatic test_busy_restart();
      int cycles;
      repeat (int'($urandom_range(2, 9))) tick();
      deal_req = 1'b1;
      tick();
      deal_req = 1'b0;
      tests_run++;
      if (valid_w[1] !== 1'b0 || left_w[1] !== 6'd52 || busy_w[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL deal_while_busy: got v=%0b left=%0d busy=%0b, expected 0 52 1", valid_w[1], left_w[1], busy_w[1]);
      end
      repeat (int'($urandom_range(5, 20))) tick();
      shuffle_req = 1'b1;
      tick();
      shuffle_req = 1'b0;
      for (int n = 0; n < NI; n++) begin
         tests_run++;
         if (obsv(n) !== expv(n) || busy_w[n] !== 1'b1) begin
            tests_failed++;
            $display("FAIL shuffle_restart inst%0d: got %h expected %h", n, obsv(n), expv(n));
         end
      end
      wait_idle(cycles);
      deal_n(52, 2);
      check_perm(2);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      deal_req     = 1'b0;
      shuffle_req  = 1'b0;
      rst_n        = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      test_reset();
      test_identity_deal();
      release_reset();
      test_auto_shuffle(0);
      release_reset();
      test_auto_shuffle(1);
      test_seed();
      test_collision();
      test_busy_restart();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The block SHALL provide parameter LFSR_SEED, default 16'hACE1: the LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 The block SHALL provide parameter AUTO_SHUFFLE, default 1: 1 = start a shuffle on reset release, 0 = stay idle with deck in identity order.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 deal_req  input  1  single-cycle pulse requesting the next card; debounced upstream.
REQ-006 shuffle_req  input  1  single-cycle pulse requesting a new shuffle and a full deck.
REQ-007 card  output  6  card index 0..51 (suit = index/13, rank = index%13), held until the next deal.
REQ-008 card_valid  output  1  one-cycle pulse marking a newly dealt card.
REQ-009 cards_left  output  6  undealt cards remaining, 0..52.
REQ-010 deck_empty  output  1  high when cards_left == 0.
REQ-011 busy  output  1  high while a shuffle is in progress.

Function
REQ-012 The deck SHALL be a 52-entry x 6-bit register array holding a permutation of 0..51 at all times outside a swap cycle.
REQ-013 A 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), SHALL advance every clock in every state.
REQ-014 The FSM SHALL have exactly the states IDLE, SHUFFLE and READY.
REQ-015 SHUFFLE: index i runs 51 down to 1; each cycle r = lfsr[5:0]; if r <= i, swap deck[i] with deck[r] and decrement i; otherwise retry next cycle with i unchanged.
REQ-016 After the swap at i == 1, the FSM SHALL enter READY on the next cycle with cards_left = 52 and the top pointer = 0.
REQ-017 busy SHALL be 1 exactly while the state is SHUFFLE.
REQ-018 In IDLE or READY, deal_req with cards_left > 0 SHALL load card = deck[top] and pulse card_valid on the following cycle (latency 1), then increment top and decrement cards_left.
REQ-019 deal_req SHALL be ignored (no card_valid, no counter change) when cards_left == 0 or busy == 1.
REQ-020 shuffle_req in any state SHALL enter SHUFFLE with i = 51, top = 0 and cards_left = 52, shuffling the current permutation in place.
REQ-021 shuffle_req during SHUFFLE SHALL restart the shuffle at i = 51.
REQ-022 When deal_req and shuffle_req arrive in the same cycle, shuffle_req SHALL win and no card SHALL be dealt.
REQ-023 deck_empty SHALL be derived combinationally from cards_left.
REQ-024 The top pointer SHALL never exceed 52; there SHALL be no wrap-around.

Reset
REQ-025 rst_n low SHALL immediately, without a clock edge, set: deck[k] = k, lfsr = LFSR_SEED, card = 0, card_valid = 0, cards_left = 52, top = 0.
REQ-026 Reset SHALL set the state to SHUFFLE with i = 51 (busy = 1) when AUTO_SHUFFLE = 1, and to IDLE (busy = 0) otherwise.
REQ-027 Reset asserted mid-shuffle or mid-deal SHALL abandon the operation with no partial card_valid.

Verification
REQ-028 AUTO_SHUFFLE=0: reset, then 52 deal pulses -> cards 0,1,...,51 in order, each with a single card_valid pulse one cycle after its request; cards_left 52->0; deck_empty = 1 after the 52nd card; a 53rd deal_req produces no card_valid.
REQ-029 AUTO_SHUFFLE=1: wait for busy to fall (>= 51 cycles), then 52 deals -> every value 0..51 appears exactly once.
REQ-030 Two runs with the same seed and identical stimulus timing -> identical card sequences; a different LFSR_SEED -> a different sequence.
REQ-031 deal_req and shuffle_req in the same cycle from READY with cards_left = 30 -> no card_valid, busy = 1 next cycle, cards_left = 52.
REQ-032 deal_req while busy = 1 -> no card_valid and cards_left unchanged; shuffle_req mid-shuffle -> busy stays high and the shuffle restarts.
REQ-033 rst_n driven low mid-shuffle between clock edges -> all outputs take their reset values before the next edge.
